// File: rtl/alu_result_fifo.sv
// alu_result_fifo: capture FIFO for the 4-bit ALU result stream.
// Each accepted word {err, cay, out[4:0]} is stored in a DEPTH-entry
// synchronous FIFO and returned on rd_* one cycle after a pop.
// Words dropped while the FIFO is full set a sticky overflow flag.
// Optional feature macro: ALU_RES_STATS_EN adds saturating err/cay counters.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [4:0]               in_out,
  input  logic                     in_err,
  input  logic                     in_cay,
  output logic                     in_ready,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [4:0]               rd_out,
  output logic                     rd_err,
  output logic                     rd_cay,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef ALU_RES_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         cay_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // storage entries are {err, cay, out[4:0]}
  logic [6:0]       mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             rd_valid_q, rd_valid_d;
  logic [6:0]       rd_word_q, rd_word_d;

  logic             push_ok;
  logic             pop_ok;
  logic             drop;

  // Handshake qualification: a pop while full frees the slot the push reuses.
  always_comb begin
    pop_ok  = rd_en & ~empty_q;
    push_ok = in_valid & (~full_q | rd_en);
    drop    = in_valid & full_q & ~rd_en;
  end

  // Next-state for pointers, occupancy flags, overflow and read register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_word_d  = rd_word_q;
    rd_valid_d = pop_ok;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_word_d = mem[rd_ptr_q];
    end
    count_d = count_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    full_d  = (count_d == OCC_W'(DEPTH));
    empty_d = (count_d == '0);
    // a new drop takes priority over a clear in the same cycle
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and read-port registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_word_q  <= rd_word_d;
    end
  end

  // Storage array write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {in_err, in_cay, in_out};
    end
  end

  // Output mapping; in_ready stays combinational so a full FIFO with rd_en can accept.
  always_comb begin
    in_ready = ~full_q | rd_en;
    rd_valid = rd_valid_q;
    rd_err   = rd_word_q[6];
    rd_cay   = rd_word_q[5];
    rd_out   = rd_word_q[4:0];
    count    = count_q;
    full     = full_q;
    empty    = empty_q;
    ovf      = ovf_q;
  end

`ifdef ALU_RES_STATS_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cay_cnt_q, cay_cnt_d;

  // Saturating flag counters; clear dominates a same-cycle push.
  always_comb begin
    err_cnt_d = err_cnt_q;
    cay_cnt_d = cay_cnt_q;
    if (stats_clr) begin
      err_cnt_d = '0;
      cay_cnt_d = '0;
    end else if (push_ok) begin
      if (in_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (in_cay && (cay_cnt_q != '1)) begin
        cay_cnt_d = cay_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      cay_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      cay_cnt_q <= cay_cnt_d;
    end
  end

  // Counter outputs.
  always_comb begin
    err_cnt = err_cnt_q;
    cay_cnt = cay_cnt_q;
  end
`endif

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream capture stage for the 4-bit ALU.
- Buffers each qualified ALU result word ({err, cay, out[4:0]}) in a small synchronous FIFO.
- Consumers read the words at their own pace; overflow is flagged.
- Sits between the ALU's registered outputs and the bus/readback logic. The upstream sequencer drives in_valid one cycle after it issues an operation.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, 8, width of the optional statistics counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result on in_* is valid this cycle.
- in_out  input  5  ALU result value.
- in_err  input  1  ALU error flag (opcode 00).
- in_cay  input  1  ALU carry flag.
- in_ready  output  1  high when a push this cycle will be accepted.
- rd_en  input  1  pop request.
- rd_valid  output  1  rd_* holds a popped word this cycle (one-cycle pulse per pop).
- rd_out  output  5  popped result.
- rd_err  output  1  popped error flag.
- rd_cay  output  1  popped carry flag.
- count  output  log2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky: a valid word was dropped.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset: while rst_n low (asynchronous assert), all outputs and state clear:
  - read/write pointers, count, rd_valid, rd_out, rd_err, rd_cay and ovf = 0;
  - empty = 1, full = 0, in_ready = 1.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries.
- Storage: DEPTH x 7-bit array, entry = {err, cay, out[4:0]}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push: accepted when in_valid and (not full, or rd_en asserted while full). Word is written at the write pointer, which then increments.
- Pop: accepted when rd_en and not empty. The read pointer entry is registered onto rd_*, rd_valid = 1 next cycle, and the read pointer increments.
  - Read latency is one cycle.
  - rd_* hold their last value when rd_valid = 0.
- Empty with rd_en: no pop, rd_valid = 0, pointers unchanged.
- Simultaneous push and pop:
  - not empty, not full: both accepted, count unchanged.
  - full: pop frees the slot and the push is accepted the same cycle, count stays DEPTH.
  - empty: pop ignored (no bypass), push accepted, count becomes 1.
- Overflow: in_valid while full and rd_en low drops the word and sets ovf next cycle. ovf stays set until ovf_clr.
  - ovf_clr and a new drop in the same cycle leave ovf = 1 (set wins).
- in_ready = !full | rd_en (combinational).
- count, full and empty are registered, derived from next-state occupancy.
- No data transformation; words leave in arrival order.

Optional Feature:
- Macro: ALU_RES_STATS_EN.
- Defined:
  - adds outputs err_cnt[CNT_W-1:0], cay_cnt[CNT_W-1:0] and input stats_clr.
  - Each accepted push increments err_cnt if in_err and cay_cnt if in_cay.
  - Both counters saturate at all-ones.
  - stats_clr zeroes both synchronously; a push in the same cycle as stats_clr leaves the counter at 0.
  - Reset clears both.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, in_ready=1, ovf=0, rd_valid=0.
- Push {err0,cay0,out=0x0A}, {0,1,0x13}, {1,0,0x00} on consecutive cycles, then rd_en for 3 cycles:
  - rd_valid pulses on the 3 following cycles;
  - rd_out = 0x0A, 0x13, 0x00 with matching flags;
  - empty=1 at end.
- DEPTH=4: push 5 words with rd_en low:
  - full=1 after the 4th;
  - 5th dropped, ovf=1;
  - ovf_clr -> ovf=0 next cycle;
  - the 4 stored words read back in order.
- Full FIFO, in_valid and rd_en together for 6 cycles:
  - count stays 4, no ovf;
  - read data equals the push sequence delayed by 4 entries;
  - pointer wrap exercised.
- Empty FIFO, rd_en with in_valid (out=0x1F): rd_valid=0 that cycle, count=1; next rd_en -> rd_out=0x1F.
- Three words pushed, rst_n pulsed low mid-stream -> immediate empty=1, count=0, rd_valid=0. With ALU_RES_STATS_EN: 260 err pushes -> err_cnt=255 (saturated), stats_clr -> 0.
